rs422_pattern_tx: RTL and testbench

Test-pattern UART transmitter for the RS422 test interface: sends a programmed byte a programmed number of times as 8N1 frames on one RS422 TX line. It is the sending end of the link whose receive side counts good and bad bytes against the same pattern. It sits behind the OPB register file, which drives its pattern, count and control strobes, and it feeds one of the TX pins (SYNC_LOC_OUT, SYNC_OUT, DMD_MSSB_TX, ENCODER_TX1/2).

---
 rtl/rs422_pattern_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_rs422_pattern_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs422_pattern_tx.sv
// rs422_pattern_tx: test-pattern 8N1 UART transmitter.
// Sends a latched byte a latched number of times (or continuously) on one
// RS422 TX line, with optional idle bit periods between frames. START, STOP
// and CLEAR are one-cycle strobes from the register file; CLEAR wins over
// STOP, which wins over START. All outputs come straight from flops.
module rs422_pattern_tx #(
  parameter int CLK_DIV  = 868,  // OPB_CLK cycles per bit, >= 4
  parameter int GAP_BITS = 0     // idle bit periods after each stop bit, 0..15
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic [7:0]  PATTERN,
  input  logic [31:0] TRANS_BYTES,
  input  logic        START,
  input  logic        STOP,
  input  logic        CLEAR,
  output logic        TX,
  output logic        BUSY,
  output logic        DONE,
  output logic        COMPLETE,
  output logic [31:0] TX_COUNT
);

  localparam int BW      = $clog2(CLK_DIV);
  // With no gap the gap counter is never used; keep it one cycle long so
  // its width and terminal value stay legal.
  localparam int GAP_CYC = (GAP_BITS > 0) ? GAP_BITS * CLK_DIV : 1;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [7:0]    pat_r, pat_n;
  logic [31:0]   len_r, len_n;
  logic          stop_pend, stop_pend_n;
  logic          tx_r, tx_n;
  logic          busy_r, busy_n;
  logic          done_r, done_n;
  logic          complete_r, complete_n;
  logic [31:0]   count_r, count_n;

  logic          baud_last;
  logic          stop_req;
  logic [31:0]   count_inc;

  assign baud_last = (baud_cnt == BAUD_LAST);
  // A STOP landing on the very cycle a frame or gap ends still counts.
  assign stop_req  = stop_pend | STOP;
  assign count_inc = count_r + 32'd1;

  assign TX       = tx_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign COMPLETE = complete_r;
  assign TX_COUNT = count_r;

  // State and datapath registers; reset leaves the line at mark (idle high).
  // NOTE: non-blocking (<=) in clocked blocks so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      pat_r      <= '0;
      len_r      <= '0;
      stop_pend  <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      complete_r <= 1'b0;
      count_r    <= '0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_idx    <= bit_n;
      gap_cnt    <= gap_n;
      pat_r      <= pat_n;
      len_r      <= len_n;
      stop_pend  <= stop_pend_n;
      tx_r       <= tx_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
      complete_r <= complete_n;
      count_r    <= count_n;
    end
  end

  // Next-state and next-output logic; the line level is computed for the
  // state being entered so TX changes on the same edge as the state.
  always_comb begin
    // NOTE: every target gets a hold/default value first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_n     = state;
    baud_n      = baud_cnt;
    bit_n       = bit_idx;
    gap_n       = gap_cnt;
    pat_n       = pat_r;
    len_n       = len_r;
    stop_pend_n = stop_pend;
    tx_n        = tx_r;
    busy_n      = busy_r;
    done_n      = 1'b0;
    complete_n  = complete_r;
    count_n     = count_r;

    if (CLEAR) begin
      // Abort immediately, truncating any frame on the wire.
      state_n     = IDLE;
      baud_n      = '0;
      bit_n       = '0;
      gap_n       = '0;
      stop_pend_n = 1'b0;
      tx_n        = 1'b1;
      busy_n      = 1'b0;
      complete_n  = 1'b0;
      count_n     = '0;
    end else begin
      if (STOP && state != IDLE) stop_pend_n = 1'b1;

      case (state)
        IDLE: begin
          if (START && !STOP) begin
            state_n     = START_BIT;
            pat_n       = PATTERN;
            len_n       = TRANS_BYTES;
            baud_n      = '0;
            stop_pend_n = 1'b0;
            tx_n        = 1'b0;
            busy_n      = 1'b1;
            complete_n  = 1'b0;
            count_n     = '0;
          end
        end

        START_BIT: begin
          if (baud_last) begin
            state_n = DATA;
            baud_n  = '0;
            bit_n   = '0;
            tx_n    = pat_r[0];
          end else begin
            baud_n = baud_cnt + BW'(1);
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_n = '0;
            if (bit_idx == 3'd7) begin
              state_n = STOP_BIT;
              tx_n    = 1'b1;
            end else begin
              bit_n = bit_idx + 3'd1;
              tx_n  = pat_r[bit_idx + 3'd1];
            end
          end else begin
            baud_n = baud_cnt + BW'(1);
          end
        end

        STOP_BIT: begin
          if (baud_last) begin
            baud_n  = '0;
            count_n = count_inc;
            if (len_r != '0 && count_inc == len_r) begin
              state_n     = IDLE;
              done_n      = 1'b1;
              complete_n  = 1'b1;
              busy_n      = 1'b0;
              stop_pend_n = 1'b0;
            end else if (stop_req) begin
              state_n     = IDLE;
              busy_n      = 1'b0;
              stop_pend_n = 1'b0;
            end else if (GAP_BITS > 0) begin
              state_n = GAP;
              gap_n   = '0;
            end else begin
              state_n = START_BIT;
              tx_n    = 1'b0;
            end
          end else begin
            baud_n = baud_cnt + BW'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_n = '0;
            if (stop_req) begin
              state_n     = IDLE;
              busy_n      = 1'b0;
              stop_pend_n = 1'b0;
            end else begin
              state_n = START_BIT;
              baud_n  = '0;
              tx_n    = 1'b0;
            end
          end else begin
            gap_n = gap_cnt + GW'(1);
          end
        end

        default: begin
          state_n = IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs422_pattern_tx.sv
// tb_rs422_pattern_tx: scoreboard bench for rs422_pattern_tx.
// A loopback UART receiver decodes the main instance's TX line and checks
// every received byte against a queue of expected bytes pushed at START.
// A second instance with a 2-bit gap is checked by sampling its line.
module tb_rs422_pattern_tx;

  localparam int D   = 16;         // short bit period keeps the run small
  localparam int FRM = 10 * D;     // cycles per frame without gap

  logic        clk;
  logic        rst;
  logic [7:0]  pattern;
  logic [31:0] trans_bytes;
  logic        start, stop, clear;
  logic        tx, busy, done, complete;
  logic [31:0] tx_count;

  logic        g_start;
  logic        g_tx, g_busy, g_done, g_complete;
  logic [31:0] g_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic        rx_flush;

  rs422_pattern_tx #(.CLK_DIV(D), .GAP_BITS(0)) u_dut (
    .OPB_CLK    (clk),
    .OPB_RST    (rst),
    .PATTERN    (pattern),
    .TRANS_BYTES(trans_bytes),
    .START      (start),
    .STOP       (stop),
    .CLEAR      (clear),
    .TX         (tx),
    .BUSY       (busy),
    .DONE       (done),
    .COMPLETE   (complete),
    .TX_COUNT   (tx_count)
  );

  rs422_pattern_tx #(.CLK_DIV(D), .GAP_BITS(2)) u_gap (
    .OPB_CLK    (clk),
    .OPB_RST    (rst),
    .PATTERN    (pattern),
    .TRANS_BYTES(trans_bytes),
    .START      (g_start),
    .STOP       (1'b0),
    .CLEAR      (1'b0),
    .TX         (g_tx),
    .BUSY       (g_busy),
    .DONE       (g_done),
    .COMPLETE   (g_complete),
    .TX_COUNT   (g_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic do_start(input logic [7:0] p, input logic [31:0] n, input int frames);
    pattern     = p;
    trans_bytes = n;
    for (int i = 0; i < frames; i++) exp_q.push_back(p);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for BUSY to fall, counting cycles and DONE pulses on the way.
  task automatic run_until_idle(input int budget, output int cyc, output int done_cnt,
                                output int done_cyc);
    cyc      = 0;
    done_cnt = 0;
    done_cyc = -1;
    while (busy && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    if (cyc >= budget) check("busy_timeout", 32'd1, 32'd0);
  endtask

  // Scoreboard side: compare one decoded frame against the expected queue.
  task automatic rx_frame(input logic sbit, input logic [7:0] data, input logic ebit);
    check("rx_start_bit", sbit, 1'b0);
    check("rx_stop_bit", ebit, 1'b1);
    if (exp_q.size() == 0) check("rx_unexpected_frame", 32'd1, 32'd0);
    else check("rx_byte", data, exp_q.pop_front());
  endtask

  // Loopback receiver: detects the start bit, samples each bit mid-period.
  int         rx_cyc;
  logic       rx_busy;
  logic [9:0] rx_bits;
  always @(negedge clk) begin
    if (rst || rx_flush) begin
      rx_busy <= 1'b0;
      rx_cyc  <= 0;
    end else if (!rx_busy) begin
      if (!tx) begin
        rx_busy <= 1'b1;
        rx_cyc  <= 1;
      end
    end else begin
      rx_cyc <= rx_cyc + 1;
      if (rx_cyc % D == D / 2) rx_bits[rx_cyc / D] <= tx;
      if (rx_cyc == 9 * D + D / 2) begin
        rx_busy <= 1'b0;
        rx_frame(rx_bits[0], rx_bits[8:1], tx);
      end
    end
  end

  initial begin
    int          cyc, dcnt, dcyc;
    logic [9:0]  frame;
    logic [21:0] seen, exp_v;
    int          rst_off[3];

    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; g_start = 1'b0;
    pattern = 8'h00; trans_bytes = 32'd0; rx_flush = 1'b0;
    tick(2);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_complete", complete, 1'b0);
    check("reset_count", tx_count, 32'd0);
    rst = 1'b0;
    tick(2);

    // Single run: 5 x 0x55 back to back.
    do_start(8'h55, 32'd5, 5);
    check("run1_busy_rise", busy, 1'b1);
    check("run1_tx_start", tx, 1'b0);
    run_until_idle(2000, cyc, dcnt, dcyc);
    check("run1_len_cycles", cyc, 5 * FRM);
    check("run1_done_cycle", dcyc, 5 * FRM);
    check("run1_done_pulses", dcnt, 1);
    check("run1_count", tx_count, 32'd5);
    check("run1_complete", complete, 1'b1);
    check("run1_tx_idle", tx, 1'b1);

    // START on the cycle after DONE is accepted and restarts the counter.
    do_start(8'h0F, 32'd1, 1);
    check("restart_busy", busy, 1'b1);
    check("restart_count", tx_count, 32'd0);
    check("restart_complete", complete, 1'b0);
    check("restart_done_low", done, 1'b0);
    run_until_idle(2000, cyc, dcnt, dcyc);
    check("restart_final_count", tx_count, 32'd1);

    // START while busy is ignored; mid-run PATTERN change has no effect.
    do_start(8'h3C, 32'd2, 2);
    tick(30);
    pattern = 8'hFF; trans_bytes = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_until_idle(2000, cyc, dcnt, dcyc);
    check("busy_start_len", cyc, 2 * FRM - 31);
    check("busy_start_count", tx_count, 32'd2);

    // Strobe collisions in IDLE.
    start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    check("start_clear_busy", busy, 1'b0);
    check("start_clear_count", tx_count, 32'd0);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    tick(1);
    check("start_stop_busy", busy, 1'b0);
    check("start_stop_tx", tx, 1'b1);

    // Gap instance: 2 x 0xA5 with 2 idle bits between frames.
    pattern = 8'hA5; trans_bytes = 32'd2;
    g_start = 1'b1;
    @(negedge clk);
    g_start = 1'b0;
    frame = {1'b1, 8'hA5, 1'b0};
    exp_v = {frame, 2'b11, frame};
    seen  = '0;
    cyc = 0; dcnt = 0; dcyc = -1;
    while (g_busy && cyc < 30 * D) begin
      if (cyc % D == D / 2 && cyc / D < 22) seen[cyc / D] = g_tx;
      @(negedge clk);
      cyc++;
      if (g_done) begin
        dcnt++;
        dcyc = cyc;
      end
    end
    check("gap_waveform", seen, exp_v);
    check("gap_done_cycle", dcyc, 22 * D);
    check("gap_done_pulses", dcnt, 1);
    check("gap_count", g_count, 32'd2);
    check("gap_complete", g_complete, 1'b1);

    // Continuous mode, STOP in the middle of frame 3.
    do_start(8'hAA, 32'd0, 3);
    tick(2 * FRM + 5 * D);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    run_until_idle(2000, cyc, dcnt, dcyc);
    check("cont_stop_len", cyc, 3 * FRM - (2 * FRM + 5 * D + 1));
    check("cont_stop_count", tx_count, 32'd3);
    check("cont_stop_done", dcnt, 0);
    check("cont_stop_complete", complete, 1'b0);

    // CLEAR during data bit 4 of frame 2.
    do_start(8'h96, 32'd10, 10);
    tick(FRM + 5 * D + 5);
    check("clear_pre_count", tx_count, 32'd1);
    clear = 1'b1; rx_flush = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_tx", tx, 1'b1);
    check("clear_count", tx_count, 32'd0);
    check("clear_busy", busy, 1'b0);
    check("clear_complete", complete, 1'b0);
    exp_q.delete();
    tick(2);
    rx_flush = 1'b0;
    do_start(8'h81, 32'd1, 1);
    run_until_idle(2000, cyc, dcnt, dcyc);
    check("clear_restart_len", cyc, FRM);
    check("clear_restart_done", dcnt, 1);
    check("clear_restart_complete", complete, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("idle_clear_complete", complete, 1'b0);
    check("idle_clear_count", tx_count, 32'd0);

    // Asynchronous reset while TX is low at several points of a run.
    rst_off = '{8, 56, FRM + 70};
    foreach (rst_off[k]) begin
      do_start(8'hC3, 32'd3, 3);
      tick(rst_off[k]);
      check("pre_rst_tx", tx, 1'b0);
      rst = 1'b1;
      #1;
      check("async_rst_tx", tx, 1'b1);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_count", tx_count, 32'd0);
      check("async_rst_complete", complete, 1'b0);
      check("async_rst_done", done, 1'b0);
      exp_q.delete();
      tick(2);
      rst = 1'b0;
      tick(1);
    end
    do_start(8'h5A, 32'd2, 2);
    run_until_idle(2000, cyc, dcnt, dcyc);
    check("post_rst_count", tx_count, 32'd2);
    check("post_rst_done", dcnt, 1);
    tick(2);
    check("pending_frames", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
